// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO: rx_done synchroniser, overrun/threshold flags, flush.
// Optional character timeout is compiled in with UART_RX_FIFO_TIMEOUT_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [`DATA_WIDTH-1:0]   rx_data_out,
  input  logic                     rx_done,
  input  logic                     prx_error,
  input  logic                     rd_en,
  output logic [`DATA_WIDTH-1:0]   rd_data,
  output logic                     rd_err,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [$clog2(DEPTH):0]   rx_thr,
  output logic                     thr_irq,
  output logic                     overrun,
  input  logic                     ovr_clr,
  input  logic                     flush,
  output logic                     timeout_irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = `DATA_WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          r_sync1, r_sync2, r_edge, r_primed, r_armed;
  logic [W:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overrun, r_rd_valid, r_rd_err;
  logic [W-1:0]  r_rd_data;
  logic          w_wr_pulse, w_pop, w_push, w_ovr_evt;

  // r_armed blocks a write until rx_done has been seen low after reset, so a word in flight at reset is ignored
  assign w_wr_pulse = r_sync2 & ~r_edge & r_armed;
  assign w_pop      = rd_en & ~empty;
  assign w_push     = w_wr_pulse & (~full | w_pop);
  assign w_ovr_evt  = w_wr_pulse & full & ~w_pop & ~flush;

  assign empty    = (r_count == '0);
  assign full     = (r_count == FULL_CNT);
  assign count    = r_count;
  assign thr_irq  = (rx_thr != '0) && (r_count >= rx_thr);
  assign overrun  = r_overrun;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_edge   <= 1'b0;
      r_primed <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_sync1  <= rx_done;
      r_sync2  <= r_sync1;
      r_edge   <= r_sync2;
      r_primed <= 1'b1;
      if (r_primed && !r_sync1) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= {prx_error, rx_data_out};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_pop & ~flush;
      if (w_pop && !flush) {r_rd_err, r_rd_data} <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET)         r_overrun <= 1'b0;
    else if (w_ovr_evt) r_overrun <= 1'b1;
    else if (ovr_clr)   r_overrun <= 1'b0;
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_to_cnt;
  logic        r_to_irq;

  // Counter saturates at the limit so the interrupt holds until activity
  always_ff @(posedge PCLK) begin
    if (PRESET || flush || w_wr_pulse || w_pop || empty) begin
      r_to_cnt <= '0;
      r_to_irq <= 1'b0;
    end else if (r_to_cnt != TO_LIM) begin
      r_to_cnt <= r_to_cnt + 16'd1;
      if (r_to_cnt + 16'd1 == TO_LIM) r_to_irq <= 1'b1;
    end
  end
  assign timeout_irq = r_to_irq;
`else
  assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int TO    = 64;

  logic        PCLK = 1'b0, PRESET = 1'b1;
  logic [31:0] rx_data_out = '0;
  logic        rx_done = 1'b0, prx_error = 1'b0, rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_err, rd_valid, empty, full, thr_irq, overrun, timeout_irq;
  logic [4:0]  count;
  logic [4:0]  rx_thr = '0;
  logic        ovr_clr = 1'b0, flush = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [32:0] model_q[$];
  bit          model_ovr = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .rx_data_out(rx_data_out), .rx_done(rx_done),
    .prx_error(prx_error), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .rd_valid(rd_valid), .empty(empty), .full(full), .count(count), .rx_thr(rx_thr),
    .thr_irq(thr_irq), .overrun(overrun), .ovr_clr(ovr_clr), .flush(flush),
    .timeout_irq(timeout_irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference: a FIFO of {err,data}; flush wins, pop before push, push dropped when still full
  function automatic void model_step(input bit wr, input logic [32:0] w, input bit rd,
                                     input bit fl, input bit clr,
                                     output bit popped, output logic [32:0] pv);
    popped = 1'b0;
    pv = '0;
    if (clr) model_ovr = 1'b0;
    if (fl) begin
      model_q.delete();
    end else begin
      if (rd && model_q.size() > 0) begin
        popped = 1'b1;
        pv = model_q.pop_front();
      end
      if (wr) begin
        if (model_q.size() < DEPTH) model_q.push_back(w);
        else model_ovr = 1'b1;
      end
    end
  endfunction

  task automatic send_word(input logic [31:0] d, input logic e, input bit pop_w,
                           input bit flush_w, input bit clr_w,
                           output logic v, output logic [31:0] rdat, output logic rerr);
    @(negedge PCLK); rx_data_out = d; prx_error = e; rx_done = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK); rd_en = pop_w; flush = flush_w; ovr_clr = clr_w;
    @(posedge PCLK); #1;
    v = rd_valid; rdat = rd_data; rerr = rd_err;
    @(negedge PCLK); rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0; rx_done = 1'b0;
    repeat (3) @(negedge PCLK);
  endtask

  task automatic do_pop(output logic v, output logic [31:0] rdat, output logic rerr);
    @(negedge PCLK); rd_en = 1'b1;
    @(posedge PCLK); #1;
    v = rd_valid; rdat = rd_data; rerr = rd_err;
    @(negedge PCLK); rd_en = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge PCLK); ovr_clr = 1'b1;
    @(negedge PCLK); ovr_clr = 1'b0;
    model_ovr = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overrun !== 1'b0 || rd_valid !== 1'b0 || thr_irq !== 1'b0 || timeout_irq !== 1'b0)
      begin errors++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", overrun, rd_valid, thr_irq, timeout_irq); end
    checks++; if (rd_data !== 32'd0 || rd_err !== 1'b0)
      begin errors++; $display("FAIL reset_rd got=%h/%b exp=0/0", rd_data, rd_err); end
    @(negedge PCLK); PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    model_q.delete(); model_ovr = 1'b0;
  endtask

  task automatic test_basic();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv; logic [4:0] c2;
    @(negedge PCLK); rx_data_out = 32'hA5A5_1234; prx_error = 1'b0; rx_done = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK); #1; c2 = count;
    @(posedge PCLK); #1;
    checks++; if (c2 !== 5'd0 || count !== 5'd1)
      begin errors++; $display("FAIL write_latency got=%0d,%0d exp=0,1", c2, count); end
    model_step(1, {1'b0, 32'hA5A5_1234}, 0, 0, 0, p, pv);
    repeat (5) @(negedge PCLK);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL one_write_per_level got=%0d exp=1", count); end
    rx_done = 1'b0;
    repeat (3) @(negedge PCLK);
    do_pop(v, d, e);
    model_step(0, '0, 1, 0, 0, p, pv);
    checks++; if (v !== 1'b1 || {e, d} !== pv || empty !== 1'b1)
      begin errors++; $display("FAIL basic_pop got=%b %b %h e%b exp=1 %b %h e1", v, e, d, empty, pv[32], pv[31:0]); end
    @(posedge PCLK); #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse got=%b exp=0", rd_valid); end
    do_pop(v, d, e);
    checks++; if (v !== 1'b0 || d !== 32'hA5A5_1234 || count !== 5'd0)
      begin errors++; $display("FAIL empty_pop got=%b %h %0d exp=0 a5a51234 0", v, d, count); end
  endtask

  task automatic test_fill_overrun();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv, w;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = {1'($urandom), 32'($urandom)};
      send_word(w[31:0], w[32], 0, 0, (i == DEPTH + 1), v, d, e);
      model_step(1, w, 0, 0, (i == DEPTH + 1), p, pv);
      if (i == DEPTH - 2) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL not_full_at_15 got=%b exp=0", full); end
      end
      if (i == DEPTH - 1) begin
        checks++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0)
          begin errors++; $display("FAIL full_at_16 got=%b %0d o%b exp=1 16 o0", full, count, overrun); end
      end
    end
    checks++; if (overrun !== 1'b1 || count !== 5'd16 || overrun !== model_ovr)
      begin errors++; $display("FAIL overrun_set got=%b %0d exp=1 16", overrun, count); end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(v, d, e);
      model_step(0, '0, 1, 0, 0, p, pv);
      checks++; if (v !== 1'b1 || {e, d} !== pv)
        begin errors++; $display("FAIL fill_pop%0d got=%b %b%h exp=1 %b%h", i, v, e, d, pv[32], pv[31:0]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty got=%b exp=1", empty); end
    do_clr();
    @(posedge PCLK); #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_full_simul();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv, w;
    for (int i = 0; i < DEPTH; i++) begin
      w = {1'($urandom), 32'($urandom)};
      send_word(w[31:0], w[32], 0, 0, 0, v, d, e);
      model_step(1, w, 0, 0, 0, p, pv);
    end
    w = {1'b1, 32'($urandom)};
    send_word(w[31:0], w[32], 1, 0, 0, v, d, e);
    model_step(1, w, 1, 0, 0, p, pv);
    checks++; if (v !== 1'b1 || {e, d} !== pv || count !== 5'd16 || overrun !== 1'b0)
      begin errors++; $display("FAIL full_simul got=%b %b%h %0d o%b exp=1 %b%h 16 o0", v, e, d, count, overrun, pv[32], pv[31:0]); end
    for (int i = 0; i < DEPTH; i++) begin
      do_pop(v, d, e);
      model_step(0, '0, 1, 0, 0, p, pv);
      checks++; if ({e, d} !== pv) begin errors++; $display("FAIL simul_drain%0d got=%b%h exp=%b%h", i, e, d, pv[32], pv[31:0]); end
    end
  endtask

  task automatic test_threshold();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv, w;
    logic exp_thr;
    rx_thr = 5'd4;
    for (int i = 1; i <= 4; i++) begin
      w = {1'b0, 32'($urandom)};
      send_word(w[31:0], w[32], 0, 0, 0, v, d, e);
      model_step(1, w, 0, 0, 0, p, pv);
      exp_thr = (i >= 4);
      checks++; if (thr_irq !== exp_thr) begin errors++; $display("FAIL thr_at_%0d got=%b exp=%b", i, thr_irq, exp_thr); end
    end
    do_pop(v, d, e);
    model_step(0, '0, 1, 0, 0, p, pv);
    checks++; if (thr_irq !== 1'b0) begin errors++; $display("FAIL thr_after_pop got=%b exp=0", thr_irq); end
    for (int i = 0; i < 6; i++) begin
      rx_thr = (i == 0) ? 5'd0 : 5'($urandom_range(1, 16));
      #1;
      exp_thr = (rx_thr != 0) && (model_q.size() >= int'(rx_thr));
      checks++; if (thr_irq !== exp_thr)
        begin errors++; $display("FAIL thr_level thr=%0d cnt=%0d got=%b exp=%b", rx_thr, count, thr_irq, exp_thr); end
    end
    rx_thr = 5'd0;
    while (model_q.size() > 0) begin
      do_pop(v, d, e);
      model_step(0, '0, 1, 0, 0, p, pv);
    end
  endtask

  task automatic test_flush();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv, w;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = {1'($urandom), 32'($urandom)};
      send_word(w[31:0], w[32], 0, 0, 0, v, d, e);
      model_step(1, w, 0, 0, 0, p, pv);
    end
    for (int i = 0; i < 11; i++) begin
      do_pop(v, d, e);
      model_step(0, '0, 1, 0, 0, p, pv);
    end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL pre_flush_count got=%0d exp=5", count); end
    w = {1'b1, 32'hDEAD_BEEF};
    send_word(w[31:0], w[32], 0, 1, 0, v, d, e);
    model_step(1, w, 0, 1, 0, p, pv);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || overrun !== model_ovr)
      begin errors++; $display("FAIL flush got=%0d e%b o%b exp=0 e1 o%b", count, empty, overrun, model_ovr); end
    w = {1'b0, 32'($urandom)};
    send_word(w[31:0], w[32], 0, 0, 0, v, d, e);
    model_step(1, w, 0, 0, 0, p, pv);
    do_pop(v, d, e);
    model_step(0, '0, 1, 0, 0, p, pv);
    checks++; if ({e, d} !== pv || empty !== 1'b1)
      begin errors++; $display("FAIL flush_discard got=%b%h exp=%b%h", e, d, pv[32], pv[31:0]); end
    do_clr();
  endtask

  task automatic test_timeout();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv;
    logic exp_irq;
    int first_bad = -1;
    @(negedge PCLK); rx_data_out = 32'h0000_0042; prx_error = 1'b0; rx_done = 1'b1;
    @(posedge PCLK);
    @(posedge PCLK);
    @(posedge PCLK); #1;
    model_step(1, {1'b0, 32'h42}, 0, 0, 0, p, pv);
    for (int k = 1; k <= TO + 6; k++) begin
      @(posedge PCLK); #1;
      if (k == 2) rx_done = 1'b0;
`ifdef UART_RX_FIFO_TIMEOUT_EN
      exp_irq = (k >= TO);
`else
      exp_irq = 1'b0;
`endif
      if (timeout_irq !== exp_irq && first_bad < 0) first_bad = k;
    end
    checks++; if (first_bad >= 0)
      begin errors++; $display("FAIL timeout_timing first wrong cycle=%0d got=%b", first_bad, timeout_irq); end
    do_pop(v, d, e);
    model_step(0, '0, 1, 0, 0, p, pv);
    checks++; if (timeout_irq !== 1'b0 || {e, d} !== pv)
      begin errors++; $display("FAIL timeout_clear got=%b %h exp=0 %h", timeout_irq, d, pv[31:0]); end
  endtask

  task automatic test_random();
    logic v, e; logic [31:0] d; bit p; logic [32:0] pv, w;
    int op; bit pw;
    do_clr();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        w = {1'($urandom), 32'($urandom)};
        pw = ($urandom_range(0, 3) == 0);
        send_word(w[31:0], w[32], pw, 0, 0, v, d, e);
        model_step(1, w, pw, 0, 0, p, pv);
      end else if (op == 2) begin
        do_pop(v, d, e);
        model_step(0, '0, 1, 0, 0, p, pv);
      end else begin
        repeat (2) @(negedge PCLK);
        p = 1'b0; v = rd_valid;
      end
      checks++; if (v !== p || (p && {e, d} !== pv))
        begin errors++; $display("FAIL rand_pop%0d got=%b %b%h exp=%b %b%h", i, v, e, d, p, pv[32], pv[31:0]); end
      checks++; if (count !== 5'(model_q.size()) || overrun !== model_ovr)
        begin errors++; $display("FAIL rand_state%0d got=%0d o%b exp=%0d o%b", i, count, overrun, model_q.size(), model_ovr); end
    end
  endtask

  task automatic test_reset_midword();
    logic v, e; logic [31:0] d;
    send_word(32'h1111_2222, 1'b1, 0, 0, 0, v, d, e);
    @(negedge PCLK); rx_data_out = 32'h3333_4444; rx_done = 1'b1;
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK);
    checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 32'd0 || overrun !== 1'b0)
      begin errors++; $display("FAIL reset_dirty got=%0d e%b %h o%b exp=0 e1 0 o0", count, empty, rd_data, overrun); end
    PRESET = 1'b0;
    repeat (8) @(negedge PCLK);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL midword_no_write got=%0d exp=0", count); end
    rx_done = 1'b0;
    repeat (3) @(negedge PCLK);
    send_word(32'h5555_6666, 1'b0, 0, 0, 0, v, d, e);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL midword_rearm got=%0d exp=1", count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overrun();
    test_full_simul();
    test_threshold();
    test_flush();
    test_timeout();
    test_random();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count (power of two, 4..256).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, idle PCLK cycles before the character timeout fires (1..65535).
REQ-003 SHALL have ports PCLK in 1 (sole clock, rising edge) and PRESET in 1 (synchronous reset, active-high).
REQ-004 SHALL have rx_data_out in `DATA_WIDTH (received word, stable while rx_done high) and rx_done in 1 (receiver done level, asynchronous to PCLK).
REQ-005 SHALL have prx_error in 1 (parity/framing error of the word, stable while rx_done high).
REQ-006 SHALL have rd_en in 1 (pop request), rd_data out `DATA_WIDTH (popped word) and rd_err out 1 (popped error flag).
REQ-007 SHALL have rd_valid out 1 (rd_data/rd_err valid pulse), empty out 1 and full out 1.
REQ-008 SHALL have count out $clog2(DEPTH)+1 (occupancy) and rx_thr in $clog2(DEPTH)+1 (threshold level).
REQ-009 SHALL have thr_irq out 1, overrun out 1 (sticky), ovr_clr in 1 and flush in 1.
REQ-010 SHALL have timeout_irq out 1.

Function
REQ-011 SHALL pass rx_done through two PCLK flops, then a third edge register; write pulse = synced & ~edge_reg.
REQ-012 SHALL write {prx_error, rx_data_out} on the write pulse; count increments on the 3rd PCLK edge after rx_done rises; one write per rx_done high period.
REQ-013 Write when full and no pop in the same cycle SHALL drop the word and set overrun; contents unchanged.
REQ-014 rd_en with empty low SHALL pop; rd_data/rd_err register the head entry and rd_valid pulses for exactly one cycle on the next edge.
REQ-015 rd_en with empty high SHALL be ignored: no pointer change, rd_valid low, rd_data holds its value.
REQ-016 Simultaneous write and pop SHALL both occur and leave count unchanged; when full this is not an overrun; when empty only the write occurs.
REQ-017 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; empty = (count==0), full = (count==DEPTH).
REQ-018 thr_irq SHALL be high when rx_thr!=0 and count>=rx_thr; rx_thr==0 SHALL hold thr_irq low.
REQ-019 flush SHALL zero pointers and count on the next edge, take priority over same-cycle write/pop, drop any same-cycle write pulse and leave overrun unchanged.
REQ-020 ovr_clr SHALL clear overrun; a same-cycle overrun event SHALL win (overrun stays 1).
REQ-021 Outputs empty, full, count, thr_irq SHALL be registered or derived from registers only (no combinational path from rd_en).

Reset
REQ-022 PRESET high at a PCLK edge SHALL force pointers, count, sync/edge flops, overrun, rd_valid and timeout state to 0, rd_data to 0 and rd_err to 0; empty SHALL read 1 and full 0.
REQ-023 Reset mid-word (rx_done high) SHALL not produce a write after release until rx_done falls and rises again.

Configuration
REQ-024 Macro UART_RX_FIFO_TIMEOUT_EN SHALL compile in the character-timeout counter (16 bits).
REQ-025 With the macro: the counter SHALL clear on any write, pop, flush or while empty, otherwise increment; timeout_irq SHALL set when it reaches TIMEOUT_CYCLES and hold until the next write, pop, flush or reset.
REQ-026 Without the macro: timeout_irq SHALL be tied 0 and no counter logic SHALL exist.

Verification
REQ-027 Reset, rx_done pulse with data 0xA5A5_1234, prx_error 0 -> count 1 after 3 edges; rd_en -> rd_valid next cycle, rd_data 0xA5A5_1234, rd_err 0, empty 1.
REQ-028 DEPTH=16, 17 words 0..16 without reads -> full 1 after 16, overrun 1 on 17th; 16 pops return 0..15 in order; ovr_clr -> overrun 0.
REQ-029 Full FIFO, write pulse and rd_en in same cycle -> count stays 16, overrun 0, popped word oldest, newest word stored.
REQ-030 rx_thr=4, write 3 words -> thr_irq 0; 4th -> thr_irq 1; one pop -> thr_irq 0; rx_thr=0 -> thr_irq 0 at any count.
REQ-031 Macro defined, TIMEOUT_CYCLES=64, one write then idle -> timeout_irq 1 exactly 64 cycles after write; rd_en -> timeout_irq 0; macro undefined -> timeout_irq always 0.
REQ-032 5 words stored, flush asserted with simultaneous write pulse -> count 0, empty 1, overrun unchanged, written word discarded.
